playlist_mcu: RTL

Parametrised music-player control unit, next-generation player controller. Sits between the one-pulsed front-panel buttons and the song player. Tracks play/pause state and the current song index over a playlist of NUM_SONGS entries. Supports next, previous, end-of-song advance with optional loop-all, and a configurable player-reset pulse length.

---
 rtl/playlist_mcu.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/playlist_mcu.sv
// playlist_mcu -- music-player control unit.
//
// Sits between the one-pulsed front-panel buttons and the song player.
// It tracks play/pause and the current song index over a playlist of
// NUM_SONGS entries. It handles next, previous and end-of-song advance,
// with optional loop-all. It also drives a player-reset pulse that lasts
// RST_CYCLES cycles on every song change.
//
// Parameters:
//   NUM_SONGS   playlist length (>= 2)
//   SONG_W      width of the song index (2**SONG_W >= NUM_SONGS)
//   RST_CYCLES  cycles reset_player is held per song change (>= 1)
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset
//   play_button   one-cycle pulse, toggles play/pause
//   next_button   one-cycle pulse, skip to next song
//   prev_button   one-cycle pulse, go to previous song
//   song_done     one-cycle pulse from the player at end of song
//   loop_all      level, wrap last -> first and keep playing
//   shuffle       level, random next/advance (only with MCU_SHUFFLE_EN)
//   play          registered, player should advance through notes
//   reset_player  registered, player must restart at note 0
//   song          registered current song index
//
// Build option:
//   MCU_SHUFFLE_EN  adds the shuffle input and an 8-bit free-running LFSR
//                   (seed 8'hA5, taps x^8+x^6+x^5+x^4+1).

module playlist_mcu #(
    parameter int NUM_SONGS  = 4,
    parameter int SONG_W     = 2,
    parameter int RST_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              prev_button,
    input  logic              song_done,
    input  logic              loop_all,
`ifdef MCU_SHUFFLE_EN
    input  logic              shuffle,
`endif
    output logic              play,
    output logic              reset_player,
    output logic [SONG_W-1:0] song
);

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [SONG_W-1:0] SONG_LAST = SONG_W'(NUM_SONGS - 1);

    typedef enum logic [1:0] {
        PAUSE,
        PLAY,
        ADV
    } state_t;

    state_t            state, state_d;
    logic              resume, resume_d;   // 1 = return to PLAY after ADV
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [SONG_W-1:0] song_d;
    logic              play_d, reset_player_d;
    logic              shuf_on;
    logic [SONG_W-1:0] shuf_song;

    function automatic logic [SONG_W-1:0] inc(input logic [SONG_W-1:0] s);
        return (s == SONG_LAST) ? '0 : s + 1'b1;
    endfunction

    function automatic logic [SONG_W-1:0] dec(input logic [SONG_W-1:0] s);
        return (s == '0) ? SONG_LAST : s - 1'b1;
    endfunction

`ifdef MCU_SHUFFLE_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr <= 8'hA5;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Random pick; if it matches the current song, step forward so a song
    // is never immediately repeated.
    always_comb begin
        shuf_on   = shuffle;
        shuf_song = SONG_W'(32'(lfsr) % NUM_SONGS);
        if (shuf_song == song) shuf_song = inc(song);
    end
`else
    assign shuf_on   = 1'b0;
    assign shuf_song = '0;
`endif

    // State register; outputs are registered from the next-state decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= PAUSE;
            resume       <= 1'b0;
            cnt          <= '0;
            song         <= '0;
            play         <= 1'b0;
            reset_player <= 1'b0;
        end else begin
            state        <= state_d;
            resume       <= resume_d;
            cnt          <= cnt_d;
            song         <= song_d;
            play         <= play_d;
            reset_player <= reset_player_d;
        end
    end

    // Next-state logic; button priority is next > prev > song_done > play.
    always_comb begin
        state_d  = state;
        resume_d = resume;
        cnt_d    = cnt;
        song_d   = song;
        unique case (state)
            PAUSE, PLAY: begin
                if (next_button) begin
                    state_d  = ADV;
                    cnt_d    = '0;
                    resume_d = (state == PLAY);
                    song_d   = shuf_on ? shuf_song : inc(song);
                end else if (prev_button) begin
                    state_d  = ADV;
                    cnt_d    = '0;
                    resume_d = (state == PLAY);
                    song_d   = dec(song);
                end else if (song_done && state == PLAY) begin
                    state_d = ADV;
                    cnt_d   = '0;
                    if (shuf_on) begin
                        song_d   = shuf_song;
                        resume_d = 1'b1;
                    end else if (song == SONG_LAST) begin
                        song_d   = '0;
                        resume_d = loop_all;
                    end else begin
                        song_d   = song + 1'b1;
                        resume_d = 1'b1;
                    end
                end else if (play_button) begin
                    state_d = (state == PLAY) ? PAUSE : PLAY;
                end
            end
            ADV: begin
                if (cnt == CNT_LAST) state_d = resume ? PLAY : PAUSE;
                else                 cnt_d   = cnt + 1'b1;
            end
            default: state_d = PAUSE;
        endcase
    end

    // Output decode (Moore on the next state, captured in the register above).
    always_comb begin
        play_d         = (state_d == PLAY);
        reset_player_d = (state_d == ADV);
    end

endmodule
